clock_set_ctrl: RTL
===================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter BLINK_CYCLES, default 25_000_000: clk cycles per blink half-period (0.5 s at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25_000_000: inc-button hold time before auto-repeat starts.
REQ-003 Parameter REPEAT_CYCLES, default 5_000_000: auto-repeat pulse spacing.
REQ-004 Parameter TIMEOUT_CYCLES, default 500_000_000: idle time in a set state before auto-commit (10 s).
REQ-005 clk  in  1  system clock, 50 MHz; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
REQ-008 btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
REQ-009 run_en  out  1  enables 1 Hz seconds counting in the timer datapath.
REQ-010 set_hr_inc  out  1  single-cycle pulse: increment hours by one (datapath wraps 23->00).
REQ-011 set_min_inc  out  1  single-cycle pulse: increment minutes by one, no carry into hours.
REQ-012 clr_sec  out  1  single-cycle pulse: clear seconds to 00 and restart the 1 Hz prescaler.
REQ-013 hr_blank, min_blank  out  1 each  blank the hour/minute 7-segment digit pairs.
REQ-014 mode  out  2  current state encoding: RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a rising-edge detector; only detected edges act.
REQ-016 An edge SHALL take effect (state change or output pulse visible) exactly 3 clk cycles after the raw input is first sampled high.
REQ-017 FSM states: RUN, SET_HR, SET_MIN, COMMIT; mode edge: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->COMMIT.
REQ-018 COMMIT SHALL last exactly one cycle, assert clr_sec for that cycle, then go to RUN unconditionally.
REQ-019 run_en SHALL be 1 in RUN, 0 in SET_HR, SET_MIN and COMMIT.
REQ-020 Inc edge in SET_HR SHALL produce one set_hr_inc pulse; in SET_MIN one set_min_inc pulse; in RUN/COMMIT it SHALL be ignored.
REQ-021 Auto-repeat: synchronized btn_inc held high continuously HOLD_CYCLES cycles after its edge SHALL produce one extra pulse, then one every REPEAT_CYCLES while held; release stops repeats immediately.
REQ-022 Mode and inc edges in the same cycle: mode wins, inc edge dropped, repeat counter cleared.
REQ-023 The state change from a mode edge SHALL clear the hold/repeat counter; an inc held across the change produces no pulse until a new edge.
REQ-024 Timeout counter SHALL clear on entry to SET_HR/SET_MIN and on any detected edge; reaching TIMEOUT_CYCLES in either set state SHALL force COMMIT.
REQ-025 Auto-repeat pulses SHALL also clear the timeout counter.
REQ-026 Blink phase SHALL toggle every BLINK_CYCLES cycles, free-running, and reset to 0 on entry to any set state.
REQ-027 hr_blank = blink phase in SET_HR, else 0; min_blank = blink phase in SET_MIN, else 0.
REQ-028 Counter widths SHALL be $clog2(param+1); all counters saturate or wrap only as stated, never overflow silently.
REQ-029 set_hr_inc, set_min_inc and clr_sec SHALL be mutually exclusive and never asserted for two consecutive cycles from one edge.

Reset
REQ-030 rst=0 SHALL immediately force: state RUN, mode=0, run_en=1, all pulses 0, blanks 0, synchronizers/edge regs 0, all counters 0.
REQ-031 Reset during SET_HR/SET_MIN SHALL abandon the set without a clr_sec pulse.
REQ-032 After rst deasserts, a button already held high SHALL register as one edge.

Verification (BLINK=4, HOLD=8, REPEAT=3, TIMEOUT=20)
REQ-033 Reset, then mode pulse -> mode=1, run_en=0 exactly 3 cycles after raw rise; hr_blank toggles every 4 cycles.
REQ-034 In SET_HR, three separate inc presses -> exactly three 1-cycle set_hr_inc pulses, no set_min_inc.
REQ-035 In SET_MIN, hold inc 20 cycles -> pulses at edge+0, +8, +11, +14, +17; none after release.
REQ-036 Three mode presses from RUN -> SET_HR, SET_MIN, then one-cycle COMMIT with clr_sec=1, then RUN, run_en=1.
REQ-037 Enter SET_HR, no input -> COMMIT exactly 20 cycles after entry, clr_sec pulse, back to RUN.
REQ-038 Mode and inc rising same cycle in SET_HR -> mode=2, no set_hr_inc; rst=0 mid-SET_MIN -> RUN, no clr_sec.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: two debounced-by-sync buttons drive a RUN / SET_HR / SET_MIN / COMMIT
// FSM with inc auto-repeat, idle auto-commit and a blink phase for the digit being set.
module clock_set_ctrl #(
   parameter int unsigned BLINK_CYCLES   = 25_000_000,
   parameter int unsigned HOLD_CYCLES    = 25_000_000,
   parameter int unsigned REPEAT_CYCLES  = 5_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       run_en,
   output logic       set_hr_inc,
   output logic       set_min_inc,
   output logic       clr_sec,
   output logic       hr_blank,
   output logic       min_blank,
   output logic [1:0] mode
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_SET_HR  = 2'd1;
   localparam logic [1:0] ST_SET_MIN = 2'd2;
   localparam logic [1:0] ST_COMMIT  = 2'd3;

   localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RPT_W = $clog2(RPT_MAX + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BL_W  = $clog2(BLINK_CYCLES + 1);

   localparam logic [RPT_W-1:0] HOLD_CNT   = RPT_W'(HOLD_CYCLES);
   localparam logic [RPT_W-1:0] REPEAT_CNT = RPT_W'(REPEAT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BL_W-1:0]  BL_LAST    = BL_W'(BLINK_CYCLES - 1);

   logic [1:0]       mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d;
   logic             mode_prev_q, mode_prev_d, inc_prev_q, inc_prev_d;
   logic             mode_edge_q, mode_edge_d, inc_edge_q, inc_edge_d;
   logic [1:0]       state_q, state_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [RPT_W-1:0] cnt_q, cnt_d;
   logic             rpt_q, rpt_d, armed_q, armed_d;
   logic [BL_W-1:0]  bcnt_q, bcnt_d;
   logic             blink_q, blink_d;
   logic             hr_inc_q, hr_inc_d, min_inc_q, min_inc_d;
   logic             in_set, rpt_fire, inc_fire, state_change, entering_set;

   // Registering the edge adds the third stage, so an edge acts 3 cycles after the raw sample.
   always_comb begin
      mode_sync_d = {mode_sync_q[0], btn_mode};
      inc_sync_d  = {inc_sync_q[0], btn_inc};
      mode_prev_d = mode_sync_q[1];
      inc_prev_d  = inc_sync_q[1];
      mode_edge_d = mode_sync_q[1] & ~mode_prev_q;
      inc_edge_d  = inc_sync_q[1] & ~inc_prev_q;
   end

   // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      to_d      = to_q;
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      armed_d   = armed_q;
      bcnt_d    = bcnt_q;
      blink_d   = blink_q;
      hr_inc_d  = 1'b0;
      min_inc_d = 1'b0;

      in_set   = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
      rpt_fire = armed_q && inc_prev_q && (rpt_q ? (cnt_q == REPEAT_CNT) : (cnt_q == HOLD_CNT));
      inc_fire = in_set && !mode_edge_q && (inc_edge_q || rpt_fire);

      case (state_q)
         ST_RUN:     if (mode_edge_q) state_d = ST_SET_HR;
         ST_SET_HR:  if (mode_edge_q) state_d = ST_SET_MIN;
                     else if (!inc_fire && to_q == TO_LAST) state_d = ST_COMMIT;
         ST_SET_MIN: if (mode_edge_q) state_d = ST_COMMIT;
                     else if (!inc_fire && to_q == TO_LAST) state_d = ST_COMMIT;
         default:    state_d = ST_RUN;
      endcase

      state_change = (state_d != state_q);
      entering_set = state_change && ((state_d == ST_SET_HR) || (state_d == ST_SET_MIN));

      if (!in_set || state_change || inc_edge_q || rpt_fire) to_d = '0;
      else                                                   to_d = to_q + TO_W'(1);

      // Arming only happens on an accepted edge, so a press held across a state change stays silent.
      if (!in_set || state_change || !inc_prev_q) begin
         armed_d = 1'b0;
         rpt_d   = 1'b0;
         cnt_d   = '0;
      end else if (inc_fire && inc_edge_q) begin
         armed_d = 1'b1;
         rpt_d   = 1'b0;
         cnt_d   = RPT_W'(1);
      end else if (rpt_fire) begin
         rpt_d   = 1'b1;
         cnt_d   = RPT_W'(1);
      end else if (armed_q) begin
         cnt_d   = cnt_q + RPT_W'(1);
      end

      if (entering_set) begin
         bcnt_d  = '0;
         blink_d = 1'b0;
      end else if (bcnt_q == BL_LAST) begin
         bcnt_d  = '0;
         blink_d = ~blink_q;
      end else begin
         bcnt_d  = bcnt_q + BL_W'(1);
      end

      hr_inc_d  = inc_fire && (state_q == ST_SET_HR);
      min_inc_d = inc_fire && (state_q == ST_SET_MIN);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_sync_q <= '0;
         inc_sync_q  <= '0;
         mode_prev_q <= 1'b0;
         inc_prev_q  <= 1'b0;
         mode_edge_q <= 1'b0;
         inc_edge_q  <= 1'b0;
         state_q     <= ST_RUN;
         to_q        <= '0;
         cnt_q       <= '0;
         rpt_q       <= 1'b0;
         armed_q     <= 1'b0;
         bcnt_q      <= '0;
         blink_q     <= 1'b0;
         hr_inc_q    <= 1'b0;
         min_inc_q   <= 1'b0;
      end else begin
         mode_sync_q <= mode_sync_d;
         inc_sync_q  <= inc_sync_d;
         mode_prev_q <= mode_prev_d;
         inc_prev_q  <= inc_prev_d;
         mode_edge_q <= mode_edge_d;
         inc_edge_q  <= inc_edge_d;
         state_q     <= state_d;
         to_q        <= to_d;
         cnt_q       <= cnt_d;
         rpt_q       <= rpt_d;
         armed_q     <= armed_d;
         bcnt_q      <= bcnt_d;
         blink_q     <= blink_d;
         hr_inc_q    <= hr_inc_d;
         min_inc_q   <= min_inc_d;
      end
   end

   assign mode        = state_q;
   assign run_en      = (state_q == ST_RUN);
   assign clr_sec     = (state_q == ST_COMMIT);
   assign set_hr_inc  = hr_inc_q;
   assign set_min_inc = min_inc_q;
   assign hr_blank    = blink_q && (state_q == ST_SET_HR);
   assign min_blank   = blink_q && (state_q == ST_SET_MIN);

endmodule
